riscv_alu: RTL and testbench

- Integer ALU for the RV32I execute stage.
- Two DATA_WIDTH operands and a 4-bit opcode feed a purely combinational result and zero flag, used in the same cycle for branch and compare decisions.
- A one-cycle registered copy of result, flag and valid feeds the writeback pipeline.

---
 rtl/alu_pkg.sv | 19 +
 rtl/riscv_alu_shifter.sv | 34 +++
 rtl/riscv_alu.sv | 109 ++++++++++
 tb/tb_riscv_alu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding for the RV32I execute-stage ALU and its shifter.
package alu_pkg;

   localparam int ALUOP_W = 4;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SRL  = 4'd3,
      ALU_SRA  = 4'd4,
      ALU_AND  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_e;

endpackage

// File: rtl/riscv_alu_shifter.sv
// Barrel shifter shared by SLL/SRL/SRA; left shifts reuse the right shifter
// by reversing the bit order on the way in and on the way out.
module riscv_alu_shifter #(
   parameter  int DATA_WIDTH = 32,
   localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [SHAMT_W-1:0]    shamt,
   input  logic                  direction,   // 1 = left, 0 = right
   input  logic                  arithmetic,  // sign fill, right shifts only
   output logic [DATA_WIDTH-1:0] result
);

   logic [DATA_WIDTH-1:0] data_rev;
   logic [DATA_WIDTH-1:0] operand;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] shifted_rev;
   logic [DATA_WIDTH:0]   ext_shift;
   logic                  fill;

   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
      assign data_rev[gi]    = data[DATA_WIDTH-1-gi];
      assign shifted_rev[gi] = shifted[DATA_WIDTH-1-gi];
   end

   assign fill    = arithmetic & ~direction & data[DATA_WIDTH-1];
   assign operand = direction ? data_rev : data;

   // One extra fill bit on top turns a signed shift into either zero or sign fill.
   assign ext_shift = $signed({fill, operand}) >>> shamt;
   assign shifted   = ext_shift[DATA_WIDTH-1:0];
   assign result    = direction ? shifted_rev : shifted;

endmodule

// File: rtl/riscv_alu.sv
// RV32I integer ALU: combinational result/zero flag plus a one-cycle registered copy.
// Define ALU_OVERFLOW_EN to add signed ADD/SUB overflow outputs.
module riscv_alu
   import alu_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] input0,
   input  logic [DATA_WIDTH-1:0] input1,
   input  logic [ALUOP_W-1:0]    aluop,
   input  logic                  in_valid,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  is_zero,
   output logic [DATA_WIDTH-1:0] out_q,
   output logic                  is_zero_q,
   output logic                  out_valid
`ifdef ALU_OVERFLOW_EN
   ,
   output logic                  overflow,
   output logic                  overflow_q
`endif
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] shift_res;
   logic                  lt_signed;
   logic                  lt_unsigned;
   logic [DATA_WIDTH-1:0] out_d;
   logic                  is_zero_d;
   logic                  valid_d;
   logic                  valid_q;

   assign sum         = input0 + input1;
   assign diff        = input0 - input1;
   assign lt_signed   = $signed(input0) < $signed(input1);
   assign lt_unsigned = input0 < input1;

   riscv_alu_shifter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shifter (
      .data       (input0),
      .shamt      (input1[SHAMT_W-1:0]),
      .direction  (aluop == ALU_SLL),
      .arithmetic (aluop == ALU_SRA),
      .result     (shift_res)
   );

   always_comb begin
      out_d = '0;
      case (aluop)
         ALU_ADD:  out_d = sum;
         ALU_SUB:  out_d = diff;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  out_d = shift_res;
         ALU_AND:  out_d = input0 & input1;
         ALU_OR:   out_d = input0 | input1;
         ALU_XOR:  out_d = input0 ^ input1;
         ALU_SLT:  out_d = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
         ALU_SLTU: out_d = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
         default:  out_d = '0;
      endcase
      is_zero_d = (out_d == '0);
      valid_d   = in_valid;
   end

   assign out       = out_d;
   assign is_zero   = is_zero_d;
   assign out_valid = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         is_zero_q <= 1'b1;
         valid_q   <= 1'b0;
      end else begin
         out_q     <= out_d;
         is_zero_q <= is_zero_d;
         valid_q   <= valid_d;
      end
   end

`ifdef ALU_OVERFLOW_EN
   logic overflow_d;

   always_comb begin
      overflow_d = 1'b0;
      case (aluop)
         ALU_ADD: overflow_d = (input0[MSB] == input1[MSB]) && (sum[MSB] != input0[MSB]);
         ALU_SUB: overflow_d = (input0[MSB] != input1[MSB]) && (diff[MSB] != input0[MSB]);
         default: overflow_d = 1'b0;
      endcase
   end

   assign overflow = overflow_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed vectors, reset behaviour and
// randomized operations against an arithmetic reference model.
module tb_riscv_alu;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] input0;
   logic [DW-1:0] input1;
   logic [3:0]    aluop;
   logic          in_valid;
   logic [DW-1:0] out;
   logic          is_zero;
   logic [DW-1:0] out_q;
   logic          is_zero_q;
   logic          out_valid;
`ifdef ALU_OVERFLOW_EN
   logic          overflow;
   logic          overflow_q;
`endif

   int checks = 0;
   int errors = 0;

   riscv_alu #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .input0    (input0),
      .input1    (input1),
      .aluop     (aluop),
      .in_valid  (in_valid),
      .out       (out),
      .is_zero   (is_zero),
      .out_q     (out_q),
      .is_zero_q (is_zero_q),
      .out_valid (out_valid)
`ifdef ALU_OVERFLOW_EN
      ,
      .overflow   (overflow),
      .overflow_q (overflow_q)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
      end
   endtask

   // Reference model: operands interpreted as integers, results reduced mod 2^32.
   function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b, input int op);
      logic [63:0] wide;
      longint      sa;
      longint      sb;
      int          sh;
      sa = a[DW-1] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
      sb = b[DW-1] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
      sh = int'(b % 32);
      case (op)
         0: begin wide = {32'b0, a} + {32'b0, b}; return wide[DW-1:0]; end
         1: begin wide = {32'b0, a} + 64'h1_0000_0000 - {32'b0, b}; return wide[DW-1:0]; end
         2: return a << sh;
         3: return a >> sh;
         4: return (a >> sh) | (a[DW-1] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         5: return a & b;
         6: return a | b;
         7: return a ^ b;
         8: return {31'b0, sa < sb};
         9: return {31'b0, a < b};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_ov(input logic [DW-1:0] a, input logic [DW-1:0] b, input int op);
      longint sa;
      longint sb;
      longint r;
      sa = a[DW-1] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
      sb = b[DW-1] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
      if (op == 0)      r = sa + sb;
      else if (op == 1) r = sa - sb;
      else              return 1'b0;
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   // Drive one operation, check combinational and then registered outputs.
   task automatic run_vec(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int op, input logic [DW-1:0] exp);
      @(negedge clk);
      input0 = a; input1 = b; aluop = 4'(op); in_valid = 1'b1;
      #1;
      check({tag, "_out"}, out, exp);
      check({tag, "_zero"}, {31'b0, is_zero}, {31'b0, exp == 0});
      @(posedge clk);
      #1;
      check({tag, "_out_q"}, out_q, exp);
      check({tag, "_zero_q"}, {31'b0, is_zero_q}, {31'b0, exp == 0});
      check({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
   endtask

   function automatic logic [DW-1:0] rnd_operand();
      case ($urandom_range(5, 0))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; input0 = '0; input1 = '0; aluop = '0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_q", out_q, 32'h0);
      check("rst_zero_q", {31'b0, is_zero_q}, 32'h1);
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      rst_n = 1'b1;

      run_vec("add_wrap", 32'hFFFF_FFFF, 32'h1, 0, 32'h0);
      run_vec("sub", 32'h5, 32'h7, 1, 32'hFFFF_FFFE);
      run_vec("slt", 32'h5, 32'h7, 8, 32'h1);
      run_vec("sltu", 32'h5, 32'h7, 9, 32'h1);
      run_vec("slt_neg", 32'hFFFF_FFFF, 32'h1, 8, 32'h1);
      run_vec("sltu_big", 32'hFFFF_FFFF, 32'h1, 9, 32'h0);
      run_vec("sll4", 32'h8000_0001, 32'h4, 2, 32'h0000_0010);
      run_vec("srl4", 32'h8000_0001, 32'h4, 3, 32'h0800_0000);
      run_vec("sra4", 32'h8000_0001, 32'h4, 4, 32'hF800_0000);
      run_vec("sll24", 32'h8000_0001, 32'h24, 2, 32'h0000_0010);
      run_vec("srl24", 32'h8000_0001, 32'h24, 3, 32'h0800_0000);
      run_vec("sra24", 32'h8000_0001, 32'h24, 4, 32'hF800_0000);
      run_vec("sll0", 32'h8000_0001, 32'h0, 2, 32'h8000_0001);
      run_vec("srl0", 32'h8000_0001, 32'h0, 3, 32'h8000_0001);
      run_vec("sra0", 32'h8000_0001, 32'h0, 4, 32'h8000_0001);
      run_vec("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 32'hF000_F000);
      run_vec("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 6, 32'hFFF0_FFF0);
      run_vec("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 7, 32'h0FF0_0FF0);
      for (int op = 10; op < 16; op++)
         run_vec($sformatf("undef%0d", op), 32'hF0F0_F0F0, 32'hFF00_FF00, op, 32'h0);

`ifdef ALU_OVERFLOW_EN
      @(negedge clk);
      input0 = 32'h7FFF_FFFF; input1 = 32'h1; aluop = 4'd0;
      #1;
      check("ovf_add", {31'b0, overflow}, 32'h1);
      @(posedge clk);
      #1;
      check("ovf_add_q", {31'b0, overflow_q}, 32'h1);
`endif

      // Reset asserted between edges while a valid 1+1 stream is running.
      @(negedge clk);
      input0 = 32'h1; input1 = 32'h1; aluop = 4'd0; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_out_q", out_q, 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_q", out_q, 32'h0);
      check("arst_zero_q", {31'b0, is_zero_q}, 32'h1);
      check("arst_valid", {31'b0, out_valid}, 32'h0);
      check("arst_out", out, 32'h2);
      @(posedge clk);
      #1;
      check("rst_hold_out_q", out_q, 32'h0);
      check("rst_hold_out", out, 32'h2);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_out_q", out_q, 32'h2);
      check("post_rst_valid", {31'b0, out_valid}, 32'h1);

      for (int i = 0; i < 10000; i++) begin
         logic [DW-1:0] a;
         logic [DW-1:0] b;
         logic [DW-1:0] exp;
         logic          v;
         int            op;
         a = rnd_operand();
         b = rnd_operand();
         op = int'($urandom_range(9, 0));
         v = 1'($urandom_range(1, 0));
         exp = model(a, b, op);
         @(negedge clk);
         input0 = a; input1 = b; aluop = 4'(op); in_valid = v;
         #1;
         check($sformatf("rnd%0d_op%0d_out", i, op), out, exp);
         check($sformatf("rnd%0d_zero", i), {31'b0, is_zero}, {31'b0, exp == 0});
`ifdef ALU_OVERFLOW_EN
         check($sformatf("rnd%0d_ovf", i), {31'b0, overflow}, {31'b0, model_ov(a, b, op)});
`endif
         @(posedge clk);
         #1;
         check($sformatf("rnd%0d_out_q", i), out_q, exp);
         check($sformatf("rnd%0d_zero_q", i), {31'b0, is_zero_q}, {31'b0, exp == 0});
         check($sformatf("rnd%0d_valid", i), {31'b0, out_valid}, {31'b0, v});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
